// File: rtl/fetch_resp_pkg.sv
// Shared types and constants for the instruction fetch responder.
package fetch_resp_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } fetch_resp_state_e;

  // Why the last response was a fault; kept as a register for debug visibility.
  typedef enum logic [1:0] {
    FC_NONE,
    FC_MISALIGN,
    FC_TIMEOUT
  } fault_cause_e;

  // Instruction fetches must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Down-counting timeout timer shared by the WAIT and DRAIN phases.
// Loaded with TIMEOUT_CYCLES on clear; expired is the terminal count (zero),
// so it asserts TIMEOUT_CYCLES enabled cycles after the clear.
module fetch_timeout_counter
  import fetch_resp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  // Reload on clear, otherwise count down while enabled and hold at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= CW'(TIMEOUT_CYCLES);
    end else if (clear) begin
      count_q <= CW'(TIMEOUT_CYCLES);
    end else if (enable && (count_q != '0)) begin
      count_q <= count_q - CW'(1);
    end
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/inst_fetch_responder.sv
// Instruction-side memory responder: turns a level-held fetch request into
// one granted memory transaction and a single-cycle dataOk_o response.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for request_i; misaligned addresses fault at once
// ST_REQ   | mem_req_o held until mem_gnt_i
// ST_WAIT  | granted, waiting for mem_rvalid_i or timeout
// ST_RESP  | dataOk_o high for this one cycle; request_i ignored
// ST_DRAIN | flushed after grant; swallow rvalid or timeout silently
module inst_fetch_responder
  import fetch_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INST       = NOP_INST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  request_i,
  input  logic [ADDR_WIDTH-1:0] instAddr_i,
  input  logic                  flush_i,
  output logic                  dataOk_o,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] instAddr_o,
  output logic                  fault_o,
  output logic                  busy_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i
);

  fetch_resp_state_e     state_q;
  fault_cause_e          cause_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  timer_clear;
  logic                  timer_en;
  logic                  timer_expired;

  // The timeout window starts at the grant; DRAIN keeps using the same window.
  assign timer_clear = (state_q == ST_REQ) && mem_gnt_i;
  assign timer_en    = (state_q == ST_WAIT) || (state_q == ST_DRAIN);

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  assign mem_addr_o = addr_q;
  assign fault_o    = (cause_q != FC_NONE);

  // Fetch sequencing FSM; every output is set on the transition into its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cause_q    <= FC_NONE;
      addr_q     <= '0;
      dataOk_o   <= 1'b0;
      inst_o     <= '0;
      instAddr_o <= '0;
      busy_o     <= 1'b0;
      mem_req_o  <= 1'b0;
    end else begin
      dataOk_o <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (request_i && !flush_i) begin
            addr_q <= instAddr_i;
            busy_o <= 1'b1;
            if (is_misaligned(instAddr_i[1:0])) begin
              state_q    <= ST_RESP;
              dataOk_o   <= 1'b1;
              inst_o     <= NOP_INST;
              instAddr_o <= instAddr_i;
              cause_q    <= FC_MISALIGN;
            end else begin
              state_q   <= ST_REQ;
              mem_req_o <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            state_q   <= flush_i ? ST_DRAIN : ST_WAIT;
          end else if (flush_i) begin
            mem_req_o <= 1'b0;
            busy_o    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (flush_i) begin
            // Data arriving with the flush is already consumed, so no drain.
            if (mem_rvalid_i) begin
              busy_o  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else if (mem_rvalid_i) begin
            state_q    <= ST_RESP;
            dataOk_o   <= 1'b1;
            inst_o     <= mem_rdata_i;
            instAddr_o <= addr_q;
            cause_q    <= FC_NONE;
          end else if (timer_expired) begin
            state_q    <= ST_RESP;
            dataOk_o   <= 1'b1;
            inst_o     <= NOP_INST;
            instAddr_o <= addr_q;
            cause_q    <= FC_TIMEOUT;
          end
        end
        ST_DRAIN: begin
          if (mem_rvalid_i || timer_expired) begin
            busy_o  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RESP: begin
          busy_o  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_o    <= 1'b0;
          mem_req_o <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
